// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register pending-write scoreboard and stall controller for a
//            4-stage MIPS pipeline. It sits beside IF/ID and counts, for each
//            architectural register, the writes that have issued but not yet
//            reached writeback. Fetch and decode stall while a source
//            register has an outstanding write, or while the destination's
//            pending counter is full. The block also keeps stall performance
//            counters.
// Ports    : clk, rst            clock / synchronous active-high reset
//            i_id_valid          instruction present in ID
//            i_id_rs, i_id_rt    source registers
//            i_id_uses_rs/rt     instruction reads rs / rt
//            i_id_writes, i_id_rd destination write enable / register
//            i_id_flush          squash the ID instruction this cycle
//            i_wb_valid, i_wb_rd register write completing this cycle
//            o_stall, o_issue    combinational stall / advance
//            o_stall_run         length of current/last stall (saturating)
//            o_stall_total       total stall cycles (saturating)
//            o_wb_err            sticky: writeback with nothing pending
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_W  = 5,
  parameter int PEND_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_id_writes,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_id_flush,
  input  logic             i_wb_valid,
  input  logic [REG_W-1:0] i_wb_rd,
  output logic             o_stall,
  output logic             o_issue,
  output logic [CNT_W-1:0] o_stall_run,
  output logic [CNT_W-1:0] o_stall_total,
  output logic             o_wb_err
);

  localparam int              c_NREG     = 2 ** REG_W;
  localparam logic [PEND_W-1:0] c_PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] c_PEND_MAX = '1;
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
  localparam logic [REG_W-1:0]  c_R0       = '0;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t            r_state;
  logic [PEND_W-1:0] r_pend [c_NREG];
  logic [CNT_W-1:0]  r_stall_run;
  logic [CNT_W-1:0]  r_stall_total;
  logic              r_wb_err;

  logic w_busy_rs;
  logic w_busy_rt;
  logic w_full;
  logic w_hazard;
  logic w_stall;
  logic w_issue;
  logic w_inc;
  logic w_dec;
  logic w_same;
  logic w_wb_orphan;

  // A writeback retiring the last pending write to a register clears the
  // hazard in the same cycle: the regfile writes before ID reads.
  // r_pend[0] is never incremented, so r0 can never appear busy.
  always_comb begin
    w_busy_rs = (r_pend[i_id_rs] != '0) &&
                !(i_wb_valid && (i_wb_rd == i_id_rs) && (r_pend[i_id_rs] == c_PEND_ONE));
    w_busy_rt = (r_pend[i_id_rt] != '0) &&
                !(i_wb_valid && (i_wb_rd == i_id_rt) && (r_pend[i_id_rt] == c_PEND_ONE));
    // Any writeback to the destination frees a slot, so the counter
    // cannot overflow when the issue goes ahead.
    w_full    = i_id_writes && (i_id_rd != c_R0) &&
                (r_pend[i_id_rd] == c_PEND_MAX) &&
                !(i_wb_valid && (i_wb_rd == i_id_rd));
    w_hazard  = (i_id_uses_rs && w_busy_rs) || (i_id_uses_rt && w_busy_rt) || w_full;
    // Flush wins over hazard: a squashed instruction neither stalls nor issues.
    w_stall   = i_id_valid && !i_id_flush && w_hazard;
    w_issue   = i_id_valid && !i_id_flush && !w_hazard;

    w_inc       = w_issue && i_id_writes && (i_id_rd != c_R0);
    w_dec       = i_wb_valid && (i_wb_rd != c_R0) && (r_pend[i_wb_rd] != '0);
    w_same      = (i_id_rd == i_wb_rd);
    w_wb_orphan = i_wb_valid && (i_wb_rd != c_R0) && (r_pend[i_wb_rd] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < c_NREG; r++) begin
        r_pend[r] <= '0;
      end
      r_state       <= S_RUN;
      r_stall_run   <= '0;
      r_stall_total <= '0;
      r_wb_err      <= 1'b0;
    end else begin
      // Net effect of issue and writeback; on the same register they cancel.
      if (w_inc && !(w_dec && w_same)) begin
        r_pend[i_id_rd] <= r_pend[i_id_rd] + c_PEND_ONE;
      end
      if (w_dec && !(w_inc && w_same)) begin
        r_pend[i_wb_rd] <= r_pend[i_wb_rd] - c_PEND_ONE;
      end

      if (w_wb_orphan) begin
        r_wb_err <= 1'b1;
      end

      if (w_stall && (r_stall_total != c_CNT_MAX)) begin
        r_stall_total <= r_stall_total + 1'b1;
      end

      case (r_state)
        S_RUN: begin
          if (w_stall) begin
            r_state     <= S_STALL;
            r_stall_run <= CNT_W'(1);
          end
        end
        S_STALL: begin
          if (w_stall) begin
            if (r_stall_run != c_CNT_MAX) begin
              r_stall_run <= r_stall_run + 1'b1;
            end
          end else begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign o_stall       = w_stall;
  assign o_issue       = w_issue;
  assign o_stall_run   = r_stall_run;
  assign o_stall_total = r_stall_total;
  assign o_wb_err      = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard. The driver applies one
//            ID/WB pattern per cycle, predicts the response from a reference
//            model of per-register pending counts and pushes it to a queue;
//            a monitor on the falling edge pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int REG_W  = 5;
  localparam int PEND_W = 2;
  localparam int CNT_W  = 16;
  localparam int NREG   = 32;
  localparam int PMAX   = 3;
  localparam int CMAX   = 65535;

  logic             clk;
  logic             rst;
  logic             i_id_valid;
  logic [REG_W-1:0] i_id_rs;
  logic [REG_W-1:0] i_id_rt;
  logic             i_id_uses_rs;
  logic             i_id_uses_rt;
  logic             i_id_writes;
  logic [REG_W-1:0] i_id_rd;
  logic             i_id_flush;
  logic             i_wb_valid;
  logic [REG_W-1:0] i_wb_rd;
  logic             o_stall;
  logic             o_issue;
  logic [CNT_W-1:0] o_stall_run;
  logic [CNT_W-1:0] o_stall_total;
  logic             o_wb_err;

  hazard_scoreboard #(.REG_W(REG_W), .PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_id_valid    (i_id_valid),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_id_uses_rs  (i_id_uses_rs),
    .i_id_uses_rt  (i_id_uses_rt),
    .i_id_writes   (i_id_writes),
    .i_id_rd       (i_id_rd),
    .i_id_flush    (i_id_flush),
    .i_wb_valid    (i_wb_valid),
    .i_wb_rd       (i_wb_rd),
    .o_stall       (o_stall),
    .o_issue       (o_issue),
    .o_stall_run   (o_stall_run),
    .o_stall_total (o_stall_total),
    .o_wb_err      (o_wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        issue;
    logic [15:0] run;
    logic [15:0] total;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: outstanding writes per register plus stall statistics.
  int m_pend[NREG];
  int m_run;
  int m_total;
  bit m_err;
  bit m_prev_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall",       32'(o_stall),       32'(e.stall));
      check("issue",       32'(o_issue),       32'(e.issue));
      check("stall_run",   32'(o_stall_run),   32'(e.run));
      check("stall_total", 32'(o_stall_total), 32'(e.total));
      check("wb_err",      32'(o_wb_err),      32'(e.err));
    end
  end

  function automatic bit m_busy(int r, bit wbv, int wbr);
    return (r != 0) && (m_pend[r] > 0) && !(wbv && wbr == r && m_pend[r] == 1);
  endfunction

  task automatic model_reset();
    foreach (m_pend[r]) m_pend[r] = 0;
    m_run = 0; m_total = 0; m_err = 0; m_prev_stall = 0;
  endtask

  // One cycle: drive, predict, enqueue, advance model, clock.
  task automatic drive(input bit r, input bit v, input int rs, input int rt,
                       input bit urs, input bit urt, input bit wr, input int rd,
                       input bit fl, input bit wbv, input int wbr);
    bit full, hz, st, is;
    exp_t e;
    rst = r; i_id_valid = v; i_id_rs = REG_W'(rs); i_id_rt = REG_W'(rt);
    i_id_uses_rs = urs; i_id_uses_rt = urt; i_id_writes = wr; i_id_rd = REG_W'(rd);
    i_id_flush = fl; i_wb_valid = wbv; i_wb_rd = REG_W'(wbr);

    full = wr && rd != 0 && m_pend[rd] == PMAX && !(wbv && wbr == rd);
    hz   = (urs && m_busy(rs, wbv, wbr)) || (urt && m_busy(rt, wbv, wbr)) || full;
    st   = v && !fl && hz;
    is   = v && !fl && !hz;
    e.stall = st; e.issue = is;
    e.run = 16'(m_run); e.total = 16'(m_total); e.err = m_err;
    exp_q.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      if (wbv && wbr != 0) begin
        if (m_pend[wbr] > 0) m_pend[wbr] -= 1;
        else m_err = 1;
      end
      if (is && wr && rd != 0) m_pend[rd] += 1;
      if (st) begin
        if (m_total < CMAX) m_total++;
        if (!m_prev_stall) m_run = 1;
        else if (m_run < CMAX) m_run++;
      end
      m_prev_stall = st;
    end
    @(posedge clk);
    #1;
  endtask

  // Shorthands: write rd, read rs, idle with optional writeback.
  task automatic wr_op(input int rd, input bit wbv, input int wbr);
    drive(0, 1, 0, 0, 0, 0, 1, rd, 0, wbv, wbr);
  endtask
  task automatic rd_op(input int rs, input bit wbv, input int wbr);
    drive(0, 1, rs, 0, 1, 0, 0, 0, 0, wbv, wbr);
  endtask
  task automatic idle(input bit wbv, input int wbr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, wbv, wbr);
  endtask

  initial begin
    rst = 1; i_id_valid = 0; i_id_rs = 0; i_id_rt = 0; i_id_uses_rs = 0;
    i_id_uses_rt = 0; i_id_writes = 0; i_id_rd = 0; i_id_flush = 0;
    i_wb_valid = 0; i_wb_rd = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    idle(0, 0);

    // RAW on r5: two stall cycles, released by same-cycle writeback
    wr_op(5, 0, 0);
    rd_op(5, 0, 0);
    rd_op(5, 0, 0);
    rd_op(5, 1, 5);
    idle(0, 0);

    // r0 is never pending
    wr_op(0, 0, 0);
    rd_op(0, 0, 0);
    idle(1, 0);
    idle(0, 0);

    // Pending counter full on r7, then same-cycle writeback lets it issue
    wr_op(7, 0, 0);
    wr_op(7, 0, 0);
    wr_op(7, 0, 0);
    wr_op(7, 0, 0);
    wr_op(7, 1, 7);
    idle(1, 7); idle(1, 7); idle(1, 7);
    rd_op(7, 0, 0);

    // Net issue/writeback on same and on different registers
    wr_op(9, 0, 0);
    wr_op(9, 1, 9);
    wr_op(4, 0, 0);
    wr_op(9, 1, 4);
    rd_op(4, 0, 0);
    rd_op(9, 0, 0);
    rd_op(9, 1, 9);
    rd_op(9, 1, 9);
    rd_op(9, 0, 0);

    // Flush beats a hazard on rt, then an orphan writeback sets wb_err
    wr_op(3, 0, 0);
    drive(0, 1, 0, 3, 0, 1, 1, 11, 1, 0, 0);
    rd_op(11, 1, 3);
    idle(1, 12);
    idle(0, 0);

    // Reset in the middle of a stall; the in-flight writeback then errs
    wr_op(6, 0, 0);
    rd_op(6, 0, 0);
    drive(1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    rd_op(6, 1, 6);
    idle(0, 0);

    // Randomised traffic over a small register window
    for (int n = 0; n < 600; n++) begin
      int pend_list[$];
      int wbr;
      bit wbv;
      pend_list.delete();
      for (int r = 1; r < 8; r++) if (m_pend[r] > 0) pend_list.push_back(r);
      wbv = ($urandom_range(0, 99) < 45);
      if (pend_list.size() > 0 && $urandom_range(0, 9) != 0)
        wbr = pend_list[$urandom_range(0, pend_list.size() - 1)];
      else
        wbr = $urandom_range(0, 7);
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 8),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 6), $urandom_range(0, 7),
            ($urandom_range(0, 9) == 0),
            wbv, wbr);
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
